// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the sequence-generator arbiter.
//   SEQ_W    : generator state width {Q1,Q2,Q3}
//   state_t  : arbiter FSM states
//   seq_next : one step of the self-correcting feedback generator
package seq_gen_pkg;

  localparam int unsigned SEQ_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Main cycle from 000 is 100,110,111,011,001,100; 010 and 101 fall back into it.
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] cur);
    logic q1, q2, q3;
    {q1, q2, q3} = cur;
    return {(~q2 & ~q1) | (q1 & ~q3), q1, q2};
  endfunction

endpackage

// File: rtl/seq_core.sv
// 3-bit feedback sequence generator register.
//   CLK   : rising-edge clock
//   RST_N : async active-low reset, loads SEED
//   step  : advance one step this edge
//   Q     : generator state {Q1,Q2,Q3}
module seq_core
  import seq_gen_pkg::*;
#(
  parameter logic [SEQ_W-1:0] SEED = 3'b000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             step,
  output logic [SEQ_W-1:0] Q
);

  // State holds between bursts; only the arbiter decides when it moves.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= SEED;
    end else if (step) begin
      Q <= seq_next(Q);
    end
  end

endmodule

// File: rtl/seq_gen_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one sequence generator between
// two requesters; each grant runs the generator for a latched burst length.
//   CLK, RST_N : clock, async active-low reset
//   REQ[1:0]   : burst requests, sampled while idle
//   LEN0, LEN1 : burst lengths, latched at grant
//   GNT        : one-hot owner of the running burst
//   Q, Q_VLD   : generator state and "produced by this burst" flag
//   DONE       : per-requester pulse on the last valid Q (or at once for LEN=0)
//   BUSY       : a burst is running
module seq_gen_arbiter
  import seq_gen_pkg::*;
#(
  parameter int unsigned      LEN_W = 4,
  parameter logic [SEQ_W-1:0] SEED  = 3'b000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       REQ,
  input  logic [LEN_W-1:0] LEN0,
  input  logic [LEN_W-1:0] LEN1,
  output logic [1:0]       GNT,
  output logic [SEQ_W-1:0] Q,
  output logic             Q_VLD,
  output logic [1:0]       DONE,
  output logic             BUSY
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             ptr;
  logic             owner;
  logic             win;
  logic [LEN_W-1:0] win_len;
  logic             step;

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    win     = (REQ == 2'b11) ? ptr : REQ[1];
    win_len = win ? LEN1 : LEN0;
  end

  assign step = (state == RUN);
  assign BUSY = (state == RUN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
      owner <= 1'b0;
      GNT   <= '0;
      Q_VLD <= 1'b0;
      DONE  <= '0;
    end else begin
      DONE  <= '0;
      Q_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ != 2'b00) begin
            cnt <= win_len;
            if (win_len != '0) begin
              state <= RUN;
              owner <= win;
              GNT   <= 2'(1) << win;
            end else begin
              // Zero-length burst completes without touching the generator.
              DONE <= 2'(1) << win;
              ptr  <= ~win;
            end
          end
        end
        RUN: begin
          Q_VLD <= 1'b1;
          cnt   <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state <= IDLE;
            DONE  <= 2'(1) << owner;
            GNT   <= '0;
            ptr   <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_core #(
    .SEED(SEED)
  ) u_core (
    .CLK  (CLK),
    .RST_N(RST_N),
    .step (step),
    .Q    (Q)
  );

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Directed bench for seq_gen_arbiter: a per-cycle vector table for the
// main arbitration/sequence behaviour, then hand sequences for the
// self-correcting seed and reset in the middle of a burst.
module tb_seq_gen_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [1:0] REQ;
  logic [3:0] LEN0, LEN1;

  logic [1:0] gnt_a, done_a, gnt_b, done_b;
  logic [2:0] q_a, q_b;
  logic       vld_a, busy_a, vld_b, busy_b;

  int checks;
  int failures;

  seq_gen_arbiter #(.LEN_W(4), .SEED(3'b000)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
    .GNT(gnt_a), .Q(q_a), .Q_VLD(vld_a), .DONE(done_a), .BUSY(busy_a)
  );

  seq_gen_arbiter #(.LEN_W(4), .SEED(3'b101)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
    .GNT(gnt_b), .Q(q_b), .Q_VLD(vld_b), .DONE(done_b), .BUSY(busy_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [2:0] q;
    logic       vld;
    logic [1:0] done;
    logic       busy;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [1:0] req, input logic [3:0] len0,
                              input logic [3:0] len1, input logic [1:0] gnt,
                              input logic [2:0] q, input logic vld,
                              input logic [1:0] done, input logic busy);
    vec_t v;
    v.req = req; v.len0 = len0; v.len1 = len1; v.gnt = gnt;
    v.q = q; v.vld = vld; v.done = done; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] gnt, input logic [2:0] q,
                         input logic vld, input logic [1:0] done, input logic busy);
    check({tag, ".gnt"},  8'(gnt_a),  8'(gnt));
    check({tag, ".q"},    8'(q_a),    8'(q));
    check({tag, ".vld"},  8'(vld_a),  8'(vld));
    check({tag, ".done"}, 8'(done_a), 8'(done));
    check({tag, ".busy"}, 8'(busy_a), 8'(busy));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // req, len0, len1 | gnt, q, vld, done, busy (outputs after the edge)
    vecs[0]  = mk(2'b01, 4'd3, 4'd0, 2'b01, 3'b000, 1'b0, 2'b00, 1'b1);
    vecs[1]  = mk(2'b00, 4'd3, 4'd0, 2'b01, 3'b100, 1'b1, 2'b00, 1'b1);
    vecs[2]  = mk(2'b00, 4'd3, 4'd0, 2'b01, 3'b110, 1'b1, 2'b00, 1'b1);
    vecs[3]  = mk(2'b00, 4'd3, 4'd0, 2'b00, 3'b111, 1'b1, 2'b01, 1'b0);
    vecs[4]  = mk(2'b10, 4'd0, 4'd4, 2'b10, 3'b111, 1'b0, 2'b00, 1'b1);
    vecs[5]  = mk(2'b10, 4'd0, 4'd4, 2'b10, 3'b011, 1'b1, 2'b00, 1'b1);
    vecs[6]  = mk(2'b00, 4'd0, 4'd4, 2'b10, 3'b001, 1'b1, 2'b00, 1'b1);
    vecs[7]  = mk(2'b00, 4'd9, 4'd9, 2'b10, 3'b100, 1'b1, 2'b00, 1'b1);
    vecs[8]  = mk(2'b00, 4'd0, 4'd0, 2'b00, 3'b110, 1'b1, 2'b10, 1'b0);
    vecs[9]  = mk(2'b11, 4'd1, 4'd1, 2'b01, 3'b110, 1'b0, 2'b00, 1'b1);
    vecs[10] = mk(2'b11, 4'd1, 4'd1, 2'b00, 3'b111, 1'b1, 2'b01, 1'b0);
    vecs[11] = mk(2'b11, 4'd1, 4'd1, 2'b10, 3'b111, 1'b0, 2'b00, 1'b1);
    vecs[12] = mk(2'b11, 4'd1, 4'd1, 2'b00, 3'b011, 1'b1, 2'b10, 1'b0);
    vecs[13] = mk(2'b11, 4'd1, 4'd1, 2'b01, 3'b011, 1'b0, 2'b00, 1'b1);
    vecs[14] = mk(2'b11, 4'd1, 4'd1, 2'b00, 3'b001, 1'b1, 2'b01, 1'b0);
    vecs[15] = mk(2'b11, 4'd1, 4'd1, 2'b10, 3'b001, 1'b0, 2'b00, 1'b1);
    vecs[16] = mk(2'b11, 4'd1, 4'd1, 2'b00, 3'b100, 1'b1, 2'b10, 1'b0);
    vecs[17] = mk(2'b01, 4'd0, 4'd1, 2'b00, 3'b100, 1'b0, 2'b01, 1'b0);
    vecs[18] = mk(2'b11, 4'd2, 4'd2, 2'b10, 3'b100, 1'b0, 2'b00, 1'b1);
    vecs[19] = mk(2'b11, 4'd2, 4'd2, 2'b10, 3'b110, 1'b1, 2'b00, 1'b1);
    vecs[20] = mk(2'b00, 4'd2, 4'd2, 2'b00, 3'b111, 1'b1, 2'b10, 1'b0);
    vecs[21] = mk(2'b00, 4'd0, 4'd0, 2'b00, 3'b111, 1'b0, 2'b00, 1'b0);

    REQ   = 2'b00;
    LEN0  = 4'd0;
    LEN1  = 4'd0;
    RST_N = 1'b0;
    tick();
    tick();
    check_a("reset", 2'b00, 3'b000, 1'b0, 2'b00, 1'b0);
    check("reset.q_b", 8'(q_b), 8'h05);
    RST_N = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      REQ  = vecs[i].req;
      LEN0 = vecs[i].len0;
      LEN1 = vecs[i].len1;
      tick();
      check_a($sformatf("row%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].vld,
              vecs[i].done, vecs[i].busy);
    end

    // Seed 101 on the second instance: first step lands on 010, then rejoins.
    REQ   = 2'b00;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    REQ   = 2'b01;
    LEN0  = 4'd3;
    tick();
    check("seed.gnt_b", 8'(gnt_b), 8'h01);
    check("seed.q_b0", 8'(q_b), 8'h05);
    REQ = 2'b00;
    tick();
    check("seed.q_b1", 8'(q_b), 8'h02);
    check("seed.vld_b1", 8'(vld_b), 8'h01);
    tick();
    check("seed.q_b2", 8'(q_b), 8'h01);
    tick();
    check("seed.q_b3", 8'(q_b), 8'h04);
    check("seed.done_b", 8'(done_b), 8'h01);
    check("seed.q_a3", 8'(q_a), 8'h07);
    tick();
    check("seed.idle_vld_b", 8'(vld_b), 8'h00);

    // Reset two steps into a LEN=5 burst aborts it with no DONE.
    REQ  = 2'b01;
    LEN0 = 4'd5;
    tick();
    check("abort.gnt", 8'(gnt_a), 8'h01);
    REQ = 2'b00;
    tick();
    check("abort.q1", 8'(q_a), 8'h03);
    tick();
    check("abort.q2", 8'(q_a), 8'h01);
    RST_N = 1'b0;
    #1;
    check_a("abort.rst", 2'b00, 3'b000, 1'b0, 2'b00, 1'b0);
    check("abort.q_b", 8'(q_b), 8'h05);
    tick();
    check("abort.hold_done", 8'(done_a), 8'h00);
    RST_N = 1'b1;
    REQ   = 2'b10;
    LEN1  = 4'd2;
    tick();
    check_a("post.grant", 2'b10, 3'b000, 1'b0, 2'b00, 1'b1);
    REQ = 2'b00;
    tick();
    check_a("post.s1", 2'b10, 3'b100, 1'b1, 2'b00, 1'b1);
    check("post.q_b1", 8'(q_b), 8'h02);
    tick();
    check_a("post.s2", 2'b00, 3'b110, 1'b1, 2'b10, 1'b0);
    check("post.done_b", 8'(done_b), 8'h02);
    tick();
    check_a("post.idle", 2'b00, 3'b110, 1'b0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
